// File: rtl/slavefifo2b_pkt_gen.sv
// slavefifo2b_pkt_gen: FX3 Slave FIFO 2-bit write generator (stream / short packet / periodic ZLP); SLAVEFIFO_PRBS_EN selects PRBS-31 data
module slavefifo2b_pkt_gen #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 12,
  parameter int GAP_CYCLES = 8,
  parameter int ZLP_PERIOD = 4
) (
  input  logic              clk_100,
  input  logic              reset_,
  input  logic              gen_en,
  input  logic [1:0]        mode_sel,
  input  logic [LEN_W-1:0]  short_len,
  input  logic              flaga_d,
  input  logic              flagb_d,
  output logic              slwr_,
  output logic              pktend_,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_done
);
  typedef enum logic [2:0] {IDLE, WAIT_FB, WRITE, WR_DLY, GAP, ZLP, ZPKT} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d, mode_in;
  logic [LEN_W-1:0] len_q, len_d, wcnt_q, wcnt_d;
  logic [15:0] gcnt_q, gcnt_d, pcnt_q, pcnt_d;
  logic last_short, gap_end, writing;
`ifdef SLAVEFIFO_PRBS_EN
  localparam logic [30:0] SEED = 31'h7FFF_FFFF;
  logic [30:0] data_q, data_d, data_nx;
  logic [31:0] data_ext;
  assign data_nx  = {data_q[29:0], data_q[30] ^ data_q[27]};
  assign data_ext = {1'b0, data_q};
  assign data_out = data_ext[DATA_W-1:0];
`else
  localparam logic [DATA_W-1:0] SEED = '0;
  logic [DATA_W-1:0] data_q, data_d, data_nx;
  assign data_nx  = data_q + DATA_W'(1);
  assign data_out = data_q;
`endif
  assign mode_in    = (mode_sel == 2'b11) ? 2'b00 : mode_sel;
  assign last_short = (mode_q == 2'b01) && (wcnt_q == len_q - LEN_W'(1));
  assign gap_end    = gcnt_q == 16'(GAP_CYCLES - 1);
  assign writing    = (state_q == WRITE) || (state_q == WR_DLY);
  // State, latched configuration, counters and data word
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      len_q   <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      pcnt_q  <= '0;
      data_q  <= SEED;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      pcnt_q  <= pcnt_d;
      data_q  <= data_d;
    end
  end
  // Next state; mode/length are captured only when a packet is launched from IDLE
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = (state_q == GAP) ? gcnt_q + 16'd1 : '0;
    data_d  = writing ? data_nx : (state_q == IDLE && !gen_en) ? SEED : data_q;
    case (state_q)
      IDLE: if (gen_en && flaga_d) begin
        mode_d  = mode_in;
        len_d   = short_len;
        state_d = (mode_in == 2'b01 && short_len == '0) ? ZLP : WAIT_FB;
      end
      WAIT_FB: if (flagb_d) begin
        state_d = WRITE;
        wcnt_d  = '0;
      end
      WRITE: begin
        wcnt_d  = wcnt_q + LEN_W'(1);
        state_d = last_short ? GAP : !flagb_d ? WR_DLY : WRITE;
      end
      WR_DLY: state_d = GAP;
      GAP: if (gap_end) begin
        if (mode_q == 2'b10 && pcnt_q == 16'(ZLP_PERIOD - 1)) begin
          pcnt_d  = '0;
          state_d = ZLP;
        end else begin
          pcnt_d  = (mode_q == 2'b10) ? pcnt_q + 16'd1 : pcnt_q;
          state_d = IDLE;
        end
      end
      ZLP:     state_d = flaga_d ? ZPKT : ZLP;
      ZPKT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Strobes decode from registered state only, so no input reaches an output combinationally
  always_comb begin
    slwr_    = !writing;
    pktend_  = !((state_q == WRITE && last_short) || state_q == ZPKT);
    pkt_done = (state_q == GAP && gap_end) || state_q == ZPKT;
  end
endmodule

// File: tb/tb_slavefifo2b_pkt_gen.sv
// tb_slavefifo2b_pkt_gen: randomized directed checks of the slave FIFO write generator against a packet-level model
module tb_slavefifo2b_pkt_gen;
  localparam int GAP = 8;
  logic clk = 1'b0, reset_ = 1'b0, gen_en = 1'b0, flaga_d = 1'b0, flagb_d = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic [11:0] short_len = '0;
  logic slwr_, pktend_, pkt_done;
  logic [31:0] data_out;
  int vectors = 0, miscompares = 0;
  typedef struct {logic slwr; logic pktend; logic [31:0] data; logic done;} ent_t;
  ent_t log_q[$];
  bit log_on = 1'b0;

  slavefifo2b_pkt_gen #(.DATA_W(32), .LEN_W(12), .GAP_CYCLES(GAP), .ZLP_PERIOD(4)) dut (
    .clk_100(clk), .reset_(reset_), .gen_en(gen_en), .mode_sel(mode_sel), .short_len(short_len),
    .flaga_d(flaga_d), .flagb_d(flagb_d), .slwr_(slwr_), .pktend_(pktend_), .data_out(data_out),
    .pkt_done(pkt_done));

  always #5 clk = ~clk;

  always @(negedge clk) if (log_on) log_q.push_back('{slwr_, pktend_, data_out, pkt_done});

  // k-th word written since the last clear
  function automatic logic [31:0] word(int k);
`ifdef SLAVEFIFO_PRBS_EN
    logic [30:0] l = 31'h7FFF_FFFF;
    for (int i = 0; i < k; i++) l = {l[29:0], l[30] ^ l[27]};
    return {1'b0, l};
`else
    return 32'(k);
`endif
  endfunction

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input string t);
    int i;
    for (i = 0; i < 40 && slwr_ !== 1'b0; i++) @(negedge clk);
    chk({t, " write start"}, i < 40, 1);
  endtask

  task automatic wait_done(input string t);
    int i;
    for (i = 0; i < 80 && pkt_done !== 1'b1; i++) @(negedge clk);
    chk({t, " pkt_done seen"}, i < 80, 1);
    step(1);
  endtask

  task automatic start(input logic [1:0] m, input logic [11:0] len);
    gen_en = 1'b0; flaga_d = 1'b1; flagb_d = 1'b1; mode_sel = m; short_len = len;
    step(2);
    chk("clear data", data_out, word(0));
    log_q.delete();
    log_on = 1'b1;
    gen_en = 1'b1;
  endtask

  // flagb_d stays high for n WRITE cycles, then drops
  task automatic stream_pkt(input string t, input int n, input bit drop_en);
    flagb_d = 1'b1;
    wait_write(t);
    if (drop_en) begin
      gen_en = 1'b0;
      mode_sel = 2'b01;
      short_len = 12'd2;
    end
    repeat (n) @(posedge clk);
    #1 flagb_d = 1'b0;
    wait_done(t);
  endtask

  task automatic short_pkt(input string t);
    flagb_d = 1'b1;
    wait_write(t);
    gen_en = 1'b0;
    mode_sel = 2'(~mode_sel);
    short_len = 12'($urandom_range(1, 3));
    wait_done(t);
  endtask

  task automatic analyze(input string t, input int ew, input int epe, input int edone,
                         input bit pe_last, input int pe_dist, input int done_dist);
    int nw = 0, npe = 0, nd = 0, lw = -1, pi = -1, di = -1;
    log_on = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].slwr === 1'b0) begin
        chk({t, " data"}, log_q[i].data, word(nw));
        nw++;
        lw = i;
      end
      if (log_q[i].pktend === 1'b0) begin npe++; pi = i; end
      if (log_q[i].done === 1'b1) begin nd++; di = i; end
    end
    chk({t, " words"}, nw, ew);
    chk({t, " pktend count"}, npe, epe);
    chk({t, " pkt_done count"}, nd, edone);
    if (pe_last) chk({t, " pktend on last word"}, pi, lw);
    if (pe_dist >= 0 && pi > 0) begin
      chk({t, " zlp position"}, pi - lw, pe_dist);
      chk({t, " zlp slwr_"}, log_q[pi].slwr, 1);
      chk({t, " zlp data hold"}, log_q[pi].data, log_q[pi-1].data);
    end
    if (done_dist >= 0) chk({t, " done position"}, di - lw, done_dist);
    chk({t, " idle slwr_"}, slwr_, 1);
  endtask

  initial begin
    int n, l, sum, d;
    step(3);
    chk("reset slwr_", slwr_, 1);
    chk("reset pktend_", pktend_, 1);
    chk("reset data_out", data_out, word(0));
    chk("reset pkt_done", pkt_done, 0);
    reset_ = 1'b1;
    step(2);
    start(2'b00, 0);
    stream_pkt("t1 stream", 10, 1);
    step(3);
    analyze("t1 stream", 12, 0, 1, 0, -1, GAP);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(0, 15);
      start($urandom_range(0, 1) ? 2'b11 : 2'b00, 12'($urandom));
      stream_pkt("rand stream", n, 1);
      step(3);
      analyze("rand stream", n + 2, 0, 1, 0, -1, GAP);
    end
    start(2'b01, 12'd5);
    short_pkt("t2 short");
    step(3);
    analyze("t2 short", 5, 1, 1, 1, -1, GAP);
    for (int r = 0; r < 3; r++) begin
      l = $urandom_range(1, 12);
      start(2'b01, 12'(l));
      short_pkt("rand short");
      step(3);
      analyze("rand short", l, 1, 1, 1, -1, GAP);
    end
    start(2'b01, 12'd20);
    stream_pkt("short early end", 3, 1);
    step(3);
    analyze("short early end", 5, 0, 1, 0, -1, GAP);
    start(2'b01, 12'd0);
    step(1);
    flaga_d = 1'b0;
    gen_en = 1'b0;
    d = $urandom_range(1, 6);
    step(d);
    chk("t4 zlp waits flaga", pktend_, 1);
    flaga_d = 1'b1;
    step(5);
    analyze("t4 zero len", 0, 1, 1, 0, -1, -1);
    reset_ = 1'b0;
    step(1);
    reset_ = 1'b1;
    start(2'b10, 0);
    sum = 0;
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(0, 6);
      sum += n + 2;
      stream_pkt("t3 zlp", n, p == 3);
    end
    step(6);
    analyze("t3 zlp", sum, 1, 5, 0, GAP + 2, GAP + 2);
    start(2'b00, 0);
    wait_write("t5 reset");
    step(2);
    #2 reset_ = 1'b0;
    #1;
    chk("t5 async slwr_", slwr_, 1);
    chk("t5 async pktend_", pktend_, 1);
    chk("t5 async data_out", data_out, word(0));
    log_on = 1'b0;
    gen_en = 1'b0;
    step(1);
    reset_ = 1'b1;
    step(3);
    chk("t5 idle slwr_", slwr_, 1);
    chk("t5 idle data_out", data_out, word(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
